// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: loads/stores over a single-outstanding req/ack bus,
// with word-alignment check, bus timeout abort and a saturating error counter.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_mem_readmem,
  input  logic        ex_mem_writemem,
  input  logic [31:0] ex_mem_regb,
  input  logic        ex_mem_selwsource,
  input  logic [4:0]  ex_mem_regdest,
  input  logic        ex_mem_writereg,
  input  logic [31:0] ex_mem_wbvalue,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_stall,
  output logic        mem_wb_writereg,
  output logic [4:0]  mem_wb_regdest,
  output logic [31:0] mem_wb_value,
  output logic        mem_err,
  output logic [7:0]  mem_err_count
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        lat_writereg;
  logic        lat_selw;
  logic [4:0]  lat_regdest;
  logic [7:0]  tcount;
  logic        mem_op;
  logic        misaligned;

  always_comb begin
    mem_op     = ex_mem_readmem | ex_mem_writemem;
    misaligned = |ex_mem_wbvalue[1:0];
  end

  assign mem_stall = (state == BUSY);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_wb_writereg <= 1'b0;
      mem_wb_regdest  <= '0;
      mem_wb_value    <= '0;
      mem_err         <= 1'b0;
      mem_err_count   <= '0;
      lat_writereg    <= 1'b0;
      lat_selw        <= 1'b0;
      lat_regdest     <= '0;
      tcount          <= '0;
    end else begin
      mem_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_op) begin
            mem_addr        <= ex_mem_wbvalue;
            mem_wdata       <= ex_mem_regb;
            lat_regdest     <= ex_mem_regdest;
            // a store (including readmem+writemem) never writes back
            lat_writereg    <= ex_mem_writereg & ~ex_mem_writemem;
            lat_selw        <= ex_mem_selwsource;
            mem_wb_writereg <= 1'b0;
            if (misaligned) begin
              mem_err <= 1'b1;
              if (mem_err_count != 8'hFF) mem_err_count <= mem_err_count + 8'd1;
            end else begin
              mem_req <= 1'b1;
              mem_we  <= ex_mem_writemem;
              tcount  <= '0;
              state   <= BUSY;
            end
          end else begin
            mem_wb_writereg <= ex_mem_writereg;
            mem_wb_regdest  <= ex_mem_regdest;
            mem_wb_value    <= ex_mem_wbvalue;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= IDLE;
            if (!mem_we) begin
              mem_wb_value    <= lat_selw ? mem_rdata : mem_addr;
              mem_wb_regdest  <= lat_regdest;
              mem_wb_writereg <= lat_writereg;
            end else begin
              mem_wb_writereg <= 1'b0;
            end
          end else if (tcount == TLAST) begin
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_wb_writereg <= 1'b0;
            mem_err         <= 1'b1;
            if (mem_err_count != 8'hFF) mem_err_count <= mem_err_count + 8'd1;
            state           <= IDLE;
          end else begin
            tcount <= tcount + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table of single-cycle vectors plus
// hand-written load/store/timeout/reset sequences.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ex_mem_readmem = 1'b0;
  logic        ex_mem_writemem = 1'b0;
  logic [31:0] ex_mem_regb = '0;
  logic        ex_mem_selwsource = 1'b0;
  logic [4:0]  ex_mem_regdest = '0;
  logic        ex_mem_writereg = 1'b0;
  logic [31:0] ex_mem_wbvalue = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_stall;
  logic        mem_wb_writereg;
  logic [4:0]  mem_wb_regdest;
  logic [31:0] mem_wb_value;
  logic        mem_err;
  logic [7:0]  mem_err_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .ex_mem_readmem(ex_mem_readmem), .ex_mem_writemem(ex_mem_writemem),
    .ex_mem_regb(ex_mem_regb), .ex_mem_selwsource(ex_mem_selwsource),
    .ex_mem_regdest(ex_mem_regdest), .ex_mem_writereg(ex_mem_writereg),
    .ex_mem_wbvalue(ex_mem_wbvalue), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .mem_wb_writereg(mem_wb_writereg),
    .mem_wb_regdest(mem_wb_regdest), .mem_wb_value(mem_wb_value),
    .mem_err(mem_err), .mem_err_count(mem_err_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] regb;
    logic        selw;
    logic [4:0]  dst;
    logic        wreg;
    logic [31:0] wbv;
    logic        e_wreg;
    logic [4:0]  e_dst;
    logic [31:0] e_val;
    logic        e_err;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] regb,
                       input logic selw, input logic [4:0] dst, input logic wreg,
                       input logic [31:0] wbv);
    ex_mem_readmem    = rd;
    ex_mem_writemem   = wr;
    ex_mem_regb       = regb;
    ex_mem_selwsource = selw;
    ex_mem_regdest    = dst;
    ex_mem_writereg   = wreg;
    ex_mem_wbvalue    = wbv;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
  endtask

  int unsigned req_cycles;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0,        1'b0, 5'd5,  1'b1, 32'h0000_1234, 1'b1, 5'd5,  32'h0000_1234, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 1'b0, 32'h0,        1'b0, 5'd7,  1'b0, 32'h0000_0055, 1'b0, 5'd7,  32'h0000_0055, 1'b0, 8'd0};
    vecs[2] = '{1'b0, 1'b0, 32'h0,        1'b0, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 8'd0};
    vecs[3] = '{1'b1, 1'b0, 32'h0,        1'b1, 5'd9,  1'b1, 32'h0000_0102, 1'b0, 5'd31, 32'hFFFF_FFFF, 1'b1, 8'd1};
    vecs[4] = '{1'b0, 1'b0, 32'h0,        1'b0, 5'd3,  1'b1, 32'h0000_0010, 1'b1, 5'd3,  32'h0000_0010, 1'b0, 8'd1};
    vecs[5] = '{1'b0, 1'b1, 32'hCAFE_0000, 1'b0, 5'd4, 1'b0, 32'h0000_0203, 1'b0, 5'd3,  32'h0000_0010, 1'b1, 8'd2};
    vecs[6] = '{1'b1, 1'b0, 32'h0,        1'b0, 5'd2,  1'b1, 32'h0000_0001, 1'b0, 5'd3,  32'h0000_0010, 1'b1, 8'd3};

    // reset state
    step();
    chk("rst_req",   32'(mem_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_wbwr",  32'(mem_wb_writereg), 32'd0);
    chk("rst_val",   mem_wb_value, 32'd0);
    chk("rst_cnt",   32'(mem_err_count), 32'd0);
    reset = 1'b0;

    // single-cycle vectors: passthrough and misaligned accesses
    for (int unsigned i = 0; i < 7; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].regb, vecs[i].selw, vecs[i].dst, vecs[i].wreg, vecs[i].wbv);
      step();
      chk($sformatf("v%0d_wbwr", i),  32'(mem_wb_writereg), 32'(vecs[i].e_wreg));
      chk($sformatf("v%0d_dst", i),   32'(mem_wb_regdest), 32'(vecs[i].e_dst));
      chk($sformatf("v%0d_val", i),   mem_wb_value, vecs[i].e_val);
      chk($sformatf("v%0d_err", i),   32'(mem_err), 32'(vecs[i].e_err));
      chk($sformatf("v%0d_cnt", i),   32'(mem_err_count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_req", i),   32'(mem_req), 32'd0);
      chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'd0);
    end

    // load at 0x100, ack in third request cycle
    drive(1'b1, 1'b0, 32'h0, 1'b1, 5'd9, 1'b1, 32'h0000_0100);
    step();
    idle_inputs();
    for (int unsigned c = 1; c <= 3; c++) begin
      chk($sformatf("ld_req_c%0d", c),   32'(mem_req), 32'd1);
      chk($sformatf("ld_stall_c%0d", c), 32'(mem_stall), 32'd1);
      chk($sformatf("ld_addr_c%0d", c),  mem_addr, 32'h0000_0100);
      chk($sformatf("ld_we_c%0d", c),    32'(mem_we), 32'd0);
      chk($sformatf("ld_wbwr_c%0d", c),  32'(mem_wb_writereg), 32'd0);
      if (c == 3) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
      step();
    end
    mem_ack = 1'b0;
    chk("ld_req_done", 32'(mem_req), 32'd0);
    chk("ld_stall_done", 32'(mem_stall), 32'd0);
    chk("ld_wbwr", 32'(mem_wb_writereg), 32'd1);
    chk("ld_dst", 32'(mem_wb_regdest), 32'd9);
    chk("ld_val", mem_wb_value, 32'hDEAD_BEEF);
    step();
    chk("ld_wbwr_1cyc", 32'(mem_wb_writereg), 32'd0);

    // store with immediate ack
    drive(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 5'd4, 1'b1, 32'h0000_0200);
    step();
    idle_inputs();
    chk("st_req", 32'(mem_req), 32'd1);
    chk("st_we", 32'(mem_we), 32'd1);
    chk("st_addr", mem_addr, 32'h0000_0200);
    chk("st_wdata", mem_wdata, 32'hCAFE_F00D);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("st_req_done", 32'(mem_req), 32'd0);
    chk("st_we_done", 32'(mem_we), 32'd0);
    chk("st_wbwr", 32'(mem_wb_writereg), 32'd0);
    chk("st_err", 32'(mem_err), 32'd0);

    // readmem+writemem together is a store, writeback suppressed
    drive(1'b1, 1'b1, 32'h1111_2222, 1'b1, 5'd6, 1'b1, 32'h0000_0204);
    step();
    idle_inputs();
    chk("rw_we", 32'(mem_we), 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    step();
    mem_ack = 1'b0;
    chk("rw_wbwr", 32'(mem_wb_writereg), 32'd0);

    // timeout: no ack, abort after 16 request cycles
    drive(1'b1, 1'b0, 32'h0, 1'b1, 5'd10, 1'b1, 32'h0000_0300);
    step();
    idle_inputs();
    req_cycles = 0;
    for (int unsigned c = 1; c <= 16; c++) begin
      if (mem_req) req_cycles++;
      chk($sformatf("to_noerr_c%0d", c), 32'(mem_err), 32'd0);
      step();
    end
    chk("to_req_cycles", req_cycles, 32'd16);
    chk("to_req_done", 32'(mem_req), 32'd0);
    chk("to_stall_done", 32'(mem_stall), 32'd0);
    chk("to_err", 32'(mem_err), 32'd1);
    chk("to_cnt", 32'(mem_err_count), 32'd4);
    chk("to_wbwr", 32'(mem_wb_writereg), 32'd0);
    step();
    chk("to_err_pulse", 32'(mem_err), 32'd0);

    // ack in the expiry cycle wins; selwsource=0 writes back the address
    drive(1'b1, 1'b0, 32'h0, 1'b0, 5'd12, 1'b1, 32'h0000_0300);
    step();
    idle_inputs();
    for (int unsigned c = 1; c <= 16; c++) begin
      if (c == 16) begin
        chk("race_req_c16", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
      end
      step();
    end
    mem_ack = 1'b0;
    chk("race_err", 32'(mem_err), 32'd0);
    chk("race_cnt", 32'(mem_err_count), 32'd4);
    chk("race_wbwr", 32'(mem_wb_writereg), 32'd1);
    chk("race_dst", 32'(mem_wb_regdest), 32'd12);
    chk("race_val", mem_wb_value, 32'h0000_0300);

    // reset mid-access clears everything immediately
    drive(1'b1, 1'b0, 32'h0, 1'b1, 5'd8, 1'b1, 32'h0000_0400);
    step();
    idle_inputs();
    step();
    chk("mid_req_busy", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_stall", 32'(mem_stall), 32'd0);
    chk("mid_rst_wbwr", 32'(mem_wb_writereg), 32'd0);
    chk("mid_rst_cnt", 32'(mem_err_count), 32'd0);
    step();
    reset = 1'b0;

    // load after reset, minimum latency
    drive(1'b1, 1'b0, 32'h0, 1'b1, 5'd7, 1'b1, 32'h0000_0500);
    step();
    idle_inputs();
    chk("pr_req", 32'(mem_req), 32'd1);
    chk("pr_addr", mem_addr, 32'h0000_0500);
    mem_ack = 1'b1;
    mem_rdata = 32'h1357_9BDF;
    step();
    mem_ack = 1'b0;
    chk("pr_wbwr", 32'(mem_wb_writereg), 32'd1);
    chk("pr_dst", 32'(mem_wb_regdest), 32'd7);
    chk("pr_val", mem_wb_value, 32'h1357_9BDF);
    chk("pr_err", 32'(mem_err), 32'd0);
    chk("pr_cnt", 32'(mem_err_count), 32'd0);
    chk("pr_stall", 32'(mem_stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of writeback. It consumes the execute stage's registered `ex_mem_*` bundle and performs loads and stores over a single-outstanding request/acknowledge data-memory bus. Outputs are stalled while an access is pending, and the stage forwards the writeback bundle `mem_wb_*`. It also enforces word alignment and a bus timeout, and keeps a saturating error counter.

## Interface
- `TIMEOUT`, default 16: maximum number of cycles `mem_req` may stay high without `mem_ack` before the access is aborted (legal range 2..255).
- `clock` in 1: sole clock; all state changes on its rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-high.
- `ex_mem_readmem` in 1: load request.
- `ex_mem_writemem` in 1: store request.
- `ex_mem_regb` in 32: store data.
- `ex_mem_selwsource` in 1: 1 = write back load data; 0 = write back `ex_mem_wbvalue`.
- `ex_mem_regdest` in 5: destination register.
- `ex_mem_writereg` in 1: register write enable.
- `ex_mem_wbvalue` in 32: ALU/shifter result; this is the byte address for loads and stores.
- `mem_ack` in 1: bus acknowledge; read data valid in the same cycle.
- `mem_rdata` in 32: bus read data.
- `mem_req` out 1: bus request, held until ack or abort.
- `mem_we` out 1: 1 = store.
- `mem_addr` out 32: byte address, always word aligned when `mem_req` is high.
- `mem_wdata` out 32: store data.
- `mem_stall` out 1: high while an access is pending; upstream must hold its bundle.
- `mem_wb_writereg` out 1: writeback enable, valid for one cycle per retired instruction.
- `mem_wb_regdest` out 5: writeback destination.
- `mem_wb_value` out 32: writeback data.
- `mem_err` out 1: one-cycle pulse on a misalignment or timeout abort.
- `mem_err_count` out 8: saturating count of `mem_err` pulses.

## Operation
- FSM has two states, IDLE and BUSY. Reset puts it in IDLE, and every output is 0.
- In IDLE, the inputs are sampled each edge:
  - **No memory op:** `mem_wb_writereg`/`regdest`/`value` <= `ex_mem_writereg`/`regdest`/`wbvalue`. Stay in IDLE.
  - **Memory op:** the block latches address, store data, regdest, writereg and selwsource.
    - If `ex_mem_wbvalue[1:0] != 0`, the access is misaligned: no bus request, `mem_err` pulses, `mem_wb_writereg` <= 0, and the FSM stays in IDLE.
    - Otherwise, `mem_req` <= 1, `mem_we` <= `ex_mem_writemem`, the timeout counter is cleared, and the FSM goes to BUSY.
  - **Both readmem and writemem high:** the access is a store, and writeback is suppressed.
  - **`mem_wb_writereg`:** forced to 0 on any memory-op edge.
- In BUSY, `ex_mem_*` inputs are ignored. The counter increments each cycle without ack.
  - **`mem_ack` = 1:** `mem_req` <= 0 and the FSM returns to IDLE.
    - Load: `mem_wb_value` <= (selwsource ? `mem_rdata` : latched address) and `mem_wb_writereg` <= latched writereg.
    - Store: `mem_wb_writereg` <= 0.
  - **Counter reaches `TIMEOUT`-1 without ack:** abort. `mem_req` <= 0, `mem_err` pulses, `mem_wb_writereg` <= 0, and the FSM returns to IDLE.
  - **Ack in the expiry cycle:** the ack wins and no error is raised.
- `mem_stall` is decoded from the state register only (BUSY). There is no combinational path from any input.
- `mem_wb_regdest`/`value` hold their last value when `mem_wb_writereg` = 0.
- `mem_err_count` increments on each `mem_err` pulse and saturates at 255.
- `mem_addr`/`mem_wdata` remain stable for the entire BUSY period.

## Timing
- Non-memory op in cycle N appears on `mem_wb_*` in cycle N+1.
- Memory op sampled at edge N:
  - `mem_req` and `mem_stall` are high from N+1.
  - Ack in cycle N+k (k ≥ 1) makes `mem_wb_*` valid and drops `mem_req`/`mem_stall` in cycle N+k+1.
  - Minimum load latency is 2 cycles.
- The first new instruction is sampled at the edge that ends the first IDLE cycle after BUSY.
- An abort occurs after exactly `TIMEOUT` cycles of `mem_req` high.
- Reset asserted mid-access immediately drops `mem_req`, `mem_stall` and `mem_wb_writereg`. The counter and FSM clear, and no error is counted.

## Test plan
- **ALU op passthrough:** ALU op with writereg=1, regdest=5, wbvalue=0x1234 -> next cycle `mem_wb_writereg`=1, regdest=5, value=0x1234; `mem_stall`=0.
- **Load:** load with address 0x100, selwsource=1, regdest=9; ack after 3 cycles with rdata=0xDEADBEEF -> `mem_req` high 3 cycles with `mem_addr`=0x100; `mem_wb_value`=0xDEADBEEF, regdest=9, one-cycle writereg; stall for 3 cycles.
- **Store:** store to 0x200 with regb=0xCAFEF00D, immediate ack -> `mem_we`=1, `mem_wdata`=0xCAFEF00D for 1 cycle; `mem_wb_writereg` stays 0.
- **Misaligned load:** load at 0x102 -> `mem_req` never rises; `mem_err` pulses; `mem_err_count`=1; `mem_wb_writereg`=0.
- **Timeout and ack race:** no ack with `TIMEOUT`=16 -> abort after 16 request cycles with an error pulse. Repeat with ack in cycle 16 -> normal completion, no error.
- **Reset mid-access:** reset asserted during BUSY -> all outputs 0 immediately. After release, a load completes normally.
